// File: rtl/me_stage.sv
// me_stage -- memory stage of the pipeline.
//
// Takes the instruction held in the EX register and either passes the ALU
// result straight to writeback (one cycle) or issues a single load/store on
// the memory request port. While a request is outstanding, stall holds the
// EX register so the instruction stays valid until mem_ack completes it.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   ex_valid, EX_*              EX-register bundle (EX_func/EX_op debug only)
//   stall                       hold EX register while a memory op is pending
//   mem_req/we/addr/wdata       memory request (held stable until mem_ack)
//   mem_ack, mem_rdata          memory completion and load data
//   ME_wbData, ME_rd, ME_wrReg  registered writeback bundle
//   fwd_valid/rd/data           forwarding taps, only with ME_FWD_EN defined
//
// Build option: define ME_FWD_EN to add the forwarding outputs.
//
// State table:
//   state  | meaning
//   IDLE   | accepting EX instructions; ALU results retire in one cycle
//   ACCESS | memory request outstanding, waiting for mem_ack

module me_stage #(
    parameter int DBITS               = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ex_valid,
    input  logic [3:0]                     EX_func,
    input  logic [3:0]                     EX_op,
    input  logic [DBITS-1:0]               EX_intermediateResult,
    input  logic [DBITS-1:0]               EX_regData2,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
    input  logic                           EX_ME_mux_sel,
    input  logic                           EX_wrReg,
    input  logic                           EX_wrMem,
    output logic                           stall,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [DBITS-1:0]               mem_addr,
    output logic [DBITS-1:0]               mem_wdata,
    input  logic                           mem_ack,
    input  logic [DBITS-1:0]               mem_rdata,
    output logic [DBITS-1:0]               ME_wbData,
    output logic [REG_INDEX_BIT_WIDTH-1:0] ME_rd,
    output logic                           ME_wrReg
`ifdef ME_FWD_EN
    ,
    output logic                           fwd_valid,
    output logic [REG_INDEX_BIT_WIDTH-1:0] fwd_rd,
    output logic [DBITS-1:0]               fwd_data
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state;
    logic   mem_op;

    // Opcode/function fields travel with the instruction for debug visibility
    // only; nothing in this stage decodes them.
    logic unused_dbg;
    assign unused_dbg = ^{EX_func, EX_op};

    // A store with mux_sel also set is still a store: wrMem decides direction.
    assign mem_op = ex_valid & (EX_wrMem | EX_ME_mux_sel);

    // Stall must be combinational so the EX register is held in the same
    // cycle the memory op is first seen and released on the ack cycle.
    always_comb begin
        stall = 1'b0;
        if (state == IDLE)
            stall = mem_op;
        else
            stall = ~mem_ack;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ME_wbData <= '0;
            ME_rd     <= '0;
            ME_wrReg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        state     <= ACCESS;
                        mem_req   <= 1'b1;
                        mem_we    <= EX_wrMem;
                        mem_addr  <= EX_intermediateResult;
                        mem_wdata <= EX_regData2;
                        ME_wrReg  <= 1'b0;
                    end else if (ex_valid) begin
                        ME_wbData <= EX_intermediateResult;
                        ME_rd     <= EX_rd;
                        ME_wrReg  <= EX_wrReg;
                    end else begin
                        ME_wrReg  <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        ME_rd   <= EX_rd;
                        // mem_we still reflects the access being completed
                        if (!mem_we) begin
                            ME_wbData <= mem_rdata;
                            ME_wrReg  <= EX_wrReg;
                        end else begin
                            ME_wrReg  <= 1'b0;
                        end
                    end else begin
                        ME_wrReg <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ME_FWD_EN
    // Derived purely from reset registers, so these are 0 out of reset.
    assign fwd_valid = ME_wrReg & (ME_rd != '0);
    assign fwd_rd    = ME_rd;
    assign fwd_data  = ME_wbData;
`endif

endmodule

// File: tb/tb_me_stage.sv
module tb_me_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [3:0]  EX_func, EX_op;
    logic [31:0] EX_intermediateResult, EX_regData2;
    logic [3:0]  EX_rd;
    logic        EX_ME_mux_sel, EX_wrReg, EX_wrMem;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ME_wbData;
    logic [3:0]  ME_rd;
    logic        ME_wrReg;
`ifdef ME_FWD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the writeback bundle should currently hold.
    logic [31:0] exp_wb;
    logic [3:0]  exp_rd;
    logic        exp_wr;

    always #5 clk = ~clk;

    me_stage #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid),
        .EX_func(EX_func), .EX_op(EX_op),
        .EX_intermediateResult(EX_intermediateResult),
        .EX_regData2(EX_regData2), .EX_rd(EX_rd),
        .EX_ME_mux_sel(EX_ME_mux_sel), .EX_wrReg(EX_wrReg), .EX_wrMem(EX_wrMem),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ME_wbData(ME_wbData), .ME_rd(ME_rd), .ME_wrReg(ME_wrReg)
`ifdef ME_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag);
        check({tag, ".wrReg"}, {31'd0, ME_wrReg}, {31'd0, exp_wr});
        check({tag, ".rd"},    {28'd0, ME_rd},    {28'd0, exp_rd});
        check({tag, ".wb"},    ME_wbData,         exp_wb);
`ifdef ME_FWD_EN
        check({tag, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, exp_wr && (exp_rd != 4'd0)});
        check({tag, ".fwd_rd"},    {28'd0, fwd_rd},    {28'd0, exp_rd});
        check({tag, ".fwd_data"},  fwd_data,           exp_wb);
`endif
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0; EX_ME_mux_sel = 1'b0; EX_wrMem = 1'b0; EX_wrReg = 1'b0;
        EX_func = 4'($urandom); EX_op = 4'($urandom);
        EX_intermediateResult = $urandom; EX_regData2 = $urandom; EX_rd = 4'($urandom);
    endtask

    // ALU instruction; a stray mem_ack is thrown in to show it is ignored.
    task automatic do_alu(input logic [31:0] res, input logic [3:0] rd, input logic wr);
        drive_idle();
        ex_valid = 1'b1; EX_intermediateResult = res; EX_rd = rd; EX_wrReg = wr;
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        #1;
        check("alu.stall", {31'd0, stall}, 32'd0);
        edge_wait();
        mem_ack = 1'b0;
        exp_wb = res; exp_rd = rd; exp_wr = wr;
        check("alu.mem_req", {31'd0, mem_req}, 32'd0);
        check_wb("alu");
    endtask

    task automatic do_bubble();
        drive_idle();
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        #1;
        check("bub.stall", {31'd0, stall}, 32'd0);
        edge_wait();
        mem_ack = 1'b0;
        exp_wr = 1'b0;
        check_wb("bub");
    endtask

    // Load or store with the ack arriving after `delay` waiting ACCESS cycles.
    task automatic do_mem(input logic is_store, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] rd,
                          input logic wr, input int delay, input logic [31:0] rdata);
        int stall_cycles;
        stall_cycles = 0;
        drive_idle();
        ex_valid = 1'b1; EX_intermediateResult = addr; EX_regData2 = wdata;
        EX_rd = rd; EX_wrReg = wr; EX_wrMem = is_store;
        EX_ME_mux_sel = is_store ? 1'($urandom) : 1'b1;
        mem_ack = 1'b0;
        #1;
        if (stall) stall_cycles++;
        edge_wait();
        check("mem.req",   {31'd0, mem_req}, 32'd1);
        check("mem.we",    {31'd0, mem_we},  {31'd0, is_store});
        check("mem.addr",  mem_addr,  addr);
        check("mem.wdata", mem_wdata, wdata);
        check("mem.wrReg0", {31'd0, ME_wrReg}, 32'd0);
        for (int i = 0; i < delay; i++) begin
            mem_ack = 1'b0; mem_rdata = $urandom;
            #1;
            if (stall) stall_cycles++;
            edge_wait();
            check("wait.req",   {31'd0, mem_req}, 32'd1);
            check("wait.we",    {31'd0, mem_we},  {31'd0, is_store});
            check("wait.addr",  mem_addr,  addr);
            check("wait.wdata", mem_wdata, wdata);
            check("wait.wrReg", {31'd0, ME_wrReg}, 32'd0);
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        #1;
        check("ack.stall", {31'd0, stall}, 32'd0);
        check("stall.cycles", stall_cycles, delay + 1);
        edge_wait();
        mem_ack = 1'b0;
        exp_rd = rd;
        if (is_store) exp_wr = 1'b0;
        else begin exp_wr = wr; exp_wb = rdata; end
        check("done.req", {31'd0, mem_req}, 32'd0);
        check_wb(is_store ? "st" : "ld");
    endtask

    initial begin
        reset = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        drive_idle();
        exp_wb = '0; exp_rd = '0; exp_wr = 1'b0;
        #3;
        check("rst.mem_req",   {31'd0, mem_req}, 32'd0);
        check("rst.mem_we",    {31'd0, mem_we},  32'd0);
        check("rst.mem_addr",  mem_addr,  32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check("rst.stall",     {31'd0, stall}, 32'd0);
        check_wb("rst");
        edge_wait();
        reset = 1'b1;
        edge_wait();

        // Directed cases
        do_alu(32'd5, 4'd3, 1'b1);
        do_mem(1'b0, 32'd2, $urandom, 4'd1, 1'b1, 3, 32'h0000CAFE);
        do_alu(32'h1234, 4'd7, 1'b1);  // back-to-back after the load
        do_mem(1'b1, 32'd5, 32'd2, 4'd4, 1'b1, 0, $urandom);
        do_alu(32'h55, 4'd0, 1'b1);    // rd=0 never forwards
        do_bubble();

        // Reset in the middle of an access, late ack after release
        drive_idle();
        ex_valid = 1'b1; EX_ME_mux_sel = 1'b1; EX_intermediateResult = 32'h40;
        EX_rd = 4'd9; EX_wrReg = 1'b1;
        edge_wait();
        check("mid.req", {31'd0, mem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        drive_idle();
        exp_wb = '0; exp_rd = '0; exp_wr = 1'b0;
        #1;
        check("mid.rst.req",   {31'd0, mem_req}, 32'd0);
        check("mid.rst.addr",  mem_addr, 32'd0);
        check("mid.rst.stall", {31'd0, stall}, 32'd0);
        check_wb("mid.rst");
        edge_wait();
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD;
        edge_wait();
        mem_ack = 1'b0;
        check("late.req",  {31'd0, mem_req}, 32'd0);
        check("late.we",   {31'd0, mem_we},  32'd0);
        check_wb("late");

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: do_alu($urandom, 4'($urandom), 1'($urandom));
                1: do_mem(1'b0, $urandom, $urandom, 4'($urandom), 1'($urandom),
                          int'($urandom_range(0, 4)), $urandom);
                2: do_mem(1'b1, $urandom, $urandom, 4'($urandom), 1'($urandom),
                          int'($urandom_range(0, 4)), $urandom);
                default: do_bubble();
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/me_stage.md
ME_STAGE -- requirements
Module: me_stage

Interface
REQ-001 Parameter DBITS, 32, data and address width.
REQ-002 Parameter REG_INDEX_BIT_WIDTH, 4, destination register index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ex_valid  input  1  EX-register bundle holds a live instruction.
REQ-006 EX_func / EX_op  input  4 each  decoded function/opcode, carried for debug only.
REQ-007 EX_intermediateResult  input  DBITS  ALU result; memory address for load/store.
REQ-008 EX_regData2  input  DBITS  store data.
REQ-009 EX_rd  input  REG_INDEX_BIT_WIDTH  destination register.
REQ-010 EX_ME_mux_sel  input  1  1 = load (writeback memory data), 0 = writeback ALU result.
REQ-011 EX_wrReg / EX_wrMem  input  1 each  register-write / memory-write enables.
REQ-012 stall  output  1  hold EX register (drives its wrt_en low).
REQ-013 mem_req / mem_we  output  1 each  memory request valid / write strobe.
REQ-014 mem_addr / mem_wdata  output  DBITS each  request address / write data.
REQ-015 mem_ack  input  1  memory completes the pending request this cycle.
REQ-016 mem_rdata  input  DBITS  load data, valid when mem_ack=1.
REQ-017 ME_wbData  output  DBITS  writeback data (registered).
REQ-018 ME_rd  output  REG_INDEX_BIT_WIDTH  writeback register index (registered).
REQ-019 ME_wrReg  output  1  writeback enable (registered).

Function
REQ-020 Memory op = ex_valid & (EX_wrMem | EX_ME_mux_sel); EX_wrMem=1 with EX_ME_mux_sel=1 shall be treated as a store.
REQ-021 FSM states IDLE, ACCESS; IDLE + memory op -> ACCESS; ACCESS + mem_ack -> IDLE; otherwise hold.
REQ-022 IDLE, non-memory op: next edge ME_wbData<=EX_intermediateResult, ME_rd<=EX_rd, ME_wrReg<=EX_wrReg; stall=0; one-cycle latency.
REQ-023 IDLE, memory op: stall=1; next edge mem_req<=1, mem_we<=EX_wrMem, mem_addr<=EX_intermediateResult, mem_wdata<=EX_regData2; ME_wrReg<=0.
REQ-024 ACCESS: mem_req, mem_we, mem_addr, mem_wdata held stable until mem_ack; stall = ~mem_ack (combinational).
REQ-025 ACCESS + mem_ack: next edge mem_req<=0; load: ME_wbData<=mem_rdata, ME_wrReg<=EX_wrReg; store: ME_wrReg<=0; ME_rd<=EX_rd.
REQ-026 ACCESS without mem_ack: ME_wrReg<=0 each edge (bubble); minimum load/store latency 2 cycles.
REQ-027 ex_valid=0 in IDLE: ME_wrReg<=0, ME_wbData/ME_rd hold.
REQ-028 mem_ack outside ACCESS shall be ignored.

Reset
REQ-029 reset=0 shall immediately force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ME_wbData=0, ME_rd=0, ME_wrReg=0; stall then follows REQ-023/024.
REQ-030 Reset during ACCESS abandons the request; a late mem_ack after release shall have no effect.

Configuration
REQ-031 Macro ME_FWD_EN defined: outputs fwd_valid (1), fwd_rd (REG_INDEX_BIT_WIDTH), fwd_data (DBITS) exist, equal ME_wrReg & (ME_rd!=0), ME_rd, ME_wbData; reset to 0.
REQ-032 ME_FWD_EN undefined: forwarding ports and logic absent; all other behaviour identical.

Verification
REQ-033 ALU op, ex_valid=1, EX_intermediateResult=5, EX_rd=3, EX_wrReg=1 -> next edge ME_wbData=5, ME_rd=3, ME_wrReg=1, stall=0, mem_req=0.
REQ-034 Load addr=2, EX_rd=1, mem_ack 3 cycles after mem_req, mem_rdata=0xCAFE -> stall high 4 cycles, req stable, then ME_wbData=0xCAFE, ME_wrReg=1.
REQ-035 Store addr=5, data=2, mem_ack on first ACCESS cycle -> mem_we=1, mem_addr=5, mem_wdata=2 one cycle, ME_wrReg=0, stall low on ack cycle.
REQ-036 reset=0 asserted mid-ACCESS, ack after release -> all outputs 0 immediately, state IDLE, no writeback.
REQ-037 Back-to-back load then ALU op -> ALU result written exactly one cycle after the load writeback, no lost instruction.
REQ-038 ME_FWD_EN defined, ALU op EX_rd=0 -> fwd_valid=0; EX_rd=3 -> fwd_valid=1, fwd_data=ME_wbData.
